// File: rtl/v_pkg.sv
// Shared types and constants for the vector issue path.
package v_pkg;

  // Functional unit indices; bit positions in issue_unit / unit_busy / unit_done.
  localparam int unsigned UNIT_ALU   = 0;
  localparam int unsigned UNIT_MUL   = 1;
  localparam int unsigned UNIT_RED   = 2;
  localparam int unsigned UNIT_SLDU  = 3;
  localparam int unsigned UNIT_LSU   = 4;
  localparam int unsigned NUM_VUNITS = 5;

  // Width of the scalar operands held in a queue entry.
  localparam int unsigned V_XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE
  } seq_state_t;

  typedef struct packed {
    logic [31:0]       instr;
    logic [V_XLEN-1:0] rs1;
    logic [V_XLEN-1:0] rs2;
  } v_entry_t;

endpackage

// File: rtl/v_instr_fifo.sv
// Synchronous FIFO with occupancy count; head is read combinationally.
module v_instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CntFull = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count_q == CntFull);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/v_issue_seq.sv
// Vector instruction queue and issue sequencer with register scoreboard.
module v_issue_seq
  import v_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned XLEN       = V_XLEN, // queue entries hold V_XLEN-wide operands
  parameter int unsigned VLMAX      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [31:0]           instr,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  output logic                  instr_ready,
  output logic [31:0]           dec_instr,
  input  logic                  dec_is_vconfig,
  input  logic [3:0]            dec_v_alu_op,
  input  logic                  dec_is_mul,
  input  logic [2:0]            dec_v_red_op,
  input  logic [2:0]            dec_v_sldu_op,
  input  logic [3:0]            dec_v_lsu_op,
  input  logic                  dec_is_vstype,
  input  logic [2:0]            dec_v_op_sel_A,
  input  logic [1:0]            dec_v_op_sel_B,
  input  logic [4:0]            dec_vd,
  input  logic [4:0]            dec_vs1,
  input  logic [4:0]            dec_vs2,
  input  logic [10:0]           dec_zimm,
  output logic                  issue_valid,
  output logic [NUM_VUNITS-1:0] issue_unit,
  output logic [31:0]           issue_instr,
  output logic [XLEN-1:0]       issue_rs1,
  output logic [XLEN-1:0]       issue_rs2,
  input  logic                  issue_ready,
  input  logic [NUM_VUNITS-1:0] unit_busy,
  input  logic [NUM_VUNITS-1:0] unit_done,
  output logic [XLEN-1:0]       vl,
  output logic [10:0]           vtype,
  output logic                  illegal_instr,
  output logic                  seq_idle
);

  localparam int unsigned     CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [XLEN-1:0] VlMaxX = XLEN'(VLMAX);

  seq_state_t state_q, state_d;

  v_entry_t            wr_entry, head;
  logic                full, empty, push, pop;
  logic [CntW-1:0]     count;

  logic [NUM_VUNITS-1:0] unit_sel;
  logic                  hazard, busy, more, handshake, issue_load, cfg_we;
  logic [XLEN-1:0]       avl, vl_new;

  logic [NUM_VUNITS-1:0]      iss_unit_q;
  logic [31:0]                iss_instr_q;
  logic [XLEN-1:0]            iss_rs1_q, iss_rs2_q;
  logic [4:0]                 iss_vd_q;
  logic                       iss_store_q;
  logic [XLEN-1:0]            vl_q;
  logic [10:0]                vtype_q;
  logic [31:0]                pending_q, pending_d;
  logic [NUM_VUNITS-1:0][4:0] unit_vd_q, unit_vd_d;
  logic [NUM_VUNITS-1:0]      unit_vd_vld_q, unit_vd_vld_d;

  assign push           = instr_valid && !full;
  assign instr_ready    = !full;
  assign wr_entry.instr = instr;
  assign wr_entry.rs1   = V_XLEN'(rs1_data);
  assign wr_entry.rs2   = V_XLEN'(rs2_data);

  v_instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(v_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign dec_instr = empty ? '0 : head.instr;

  // Target unit from decoded head, fixed priority LSU > MUL > RED > SLDU > ALU.
  always_comb begin
    unit_sel = '0;
    if (dec_v_lsu_op != 4'd0)       unit_sel[UNIT_LSU]  = 1'b1;
    else if (dec_is_mul)            unit_sel[UNIT_MUL]  = 1'b1;
    else if (dec_v_red_op != 3'd0)  unit_sel[UNIT_RED]  = 1'b1;
    else if (dec_v_sldu_op != 3'd0) unit_sel[UNIT_SLDU] = 1'b1;
    else if (dec_v_alu_op != 4'd0)  unit_sel[UNIT_ALU]  = 1'b1;
  end

  // RAW on vs1/vs2 (a store reads its data from vs1) and WAW on vd for non-stores.
  always_comb begin
    hazard = (dec_v_op_sel_A == 3'd1 && pending_q[dec_vs1]) ||
             (dec_is_vstype && pending_q[dec_vs1]) ||
             (dec_v_op_sel_B == 2'd1 && pending_q[dec_vs2]) ||
             (!dec_is_vstype && pending_q[dec_vd]);
    busy   = |(unit_sel & unit_busy);
  end

  // vsetvli: rs1=x0 with rd!=x0 requests the maximum length.
  always_comb begin
    avl = XLEN'(head.rs1);
    if (head.instr[19:15] == 5'd0 && head.instr[11:7] != 5'd0) avl = VlMaxX;
    vl_new = (avl > VlMaxX) ? VlMaxX : avl;
  end

  // Entries left after the pop this cycle decide CHECK vs IDLE.
  assign more = (count > CntOne) || push;

  // Sequencer next state and single-cycle controls.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    cfg_we        = 1'b0;
    issue_load    = 1'b0;
    handshake     = 1'b0;
    illegal_instr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (dec_is_vconfig) begin
          cfg_we  = 1'b1;
          pop     = 1'b1;
          state_d = more ? S_CHECK : S_IDLE;
        end else if (unit_sel == '0) begin
          illegal_instr = 1'b1;
          pop           = 1'b1;
          state_d       = more ? S_CHECK : S_IDLE;
        end else if (!hazard && !busy) begin
          issue_load = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_ready) begin
          handshake = 1'b1;
          pop       = 1'b1;
          state_d   = more ? S_CHECK : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scoreboard update: clears from completions first so a same-cycle set wins.
  always_comb begin
    pending_d     = pending_q;
    unit_vd_d     = unit_vd_q;
    unit_vd_vld_d = unit_vd_vld_q;
    for (int unsigned u = 0; u < NUM_VUNITS; u++) begin
      if (unit_done[u] && unit_vd_vld_q[u]) begin
        pending_d[unit_vd_q[u]] = 1'b0;
        unit_vd_vld_d[u]        = 1'b0;
      end
    end
    if (handshake && !iss_store_q) begin
      pending_d[iss_vd_q] = 1'b1;
      for (int unsigned u = 0; u < NUM_VUNITS; u++) begin
        if (iss_unit_q[u]) begin
          unit_vd_d[u]     = iss_vd_q;
          unit_vd_vld_d[u] = 1'b1;
        end
      end
    end
  end

  // State, architectural config and scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      vl_q          <= '0;
      vtype_q       <= '0;
      pending_q     <= '0;
      unit_vd_q     <= '0;
      unit_vd_vld_q <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      unit_vd_q     <= unit_vd_d;
      unit_vd_vld_q <= unit_vd_vld_d;
      if (cfg_we) begin
        vl_q    <= vl_new;
        vtype_q <= dec_zimm;
      end
    end
  end

  // Issue payload is captured on entry to S_ISSUE so it stays stable until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_unit_q  <= '0;
      iss_instr_q <= '0;
      iss_rs1_q   <= '0;
      iss_rs2_q   <= '0;
      iss_vd_q    <= '0;
      iss_store_q <= 1'b0;
    end else if (issue_load) begin
      iss_unit_q  <= unit_sel;
      iss_instr_q <= head.instr;
      iss_rs1_q   <= XLEN'(head.rs1);
      iss_rs2_q   <= XLEN'(head.rs2);
      iss_vd_q    <= dec_vd;
      iss_store_q <= dec_is_vstype;
    end else if (handshake) begin
      iss_unit_q  <= '0;
    end
  end

  assign issue_valid = (state_q == S_ISSUE);
  assign issue_unit  = iss_unit_q;
  assign issue_instr = iss_instr_q;
  assign issue_rs1   = iss_rs1_q;
  assign issue_rs2   = iss_rs2_q;
  assign vl          = vl_q;
  assign vtype       = vtype_q;
  assign seq_idle    = (state_q == S_IDLE) && (pending_q == '0);

endmodule

// File: doc/v_issue_seq.md
Name: v_issue_seq

Overview:
- Vector instruction queue and issue sequencer. Sits between the scalar core's vector-instruction offload port and the vector decoder / functional units.
- Buffers offloaded vector instructions with their scalar operands and presents the queue head to the decoder.
- Reads the decoded control fields back, resolves unit-busy and vector-register hazards, and issues each instruction to exactly one functional unit via a valid/ready handshake.
- Executes vsetvli-type configuration internally and holds the architectural vl/vtype.

Parameters:
- FIFO_DEPTH, 4, instruction queue entries (power of 2, at least 2).
- XLEN, 32, scalar operand width.
- VLMAX, 32, maximum vector length in elements (fits XLEN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  offload request from scalar core
- instr  in  32  vector instruction
- rs1_data  in  XLEN  scalar rs1 value captured with instr
- rs2_data  in  XLEN  scalar rs2 value captured with instr
- instr_ready  out  1  queue can accept
- dec_instr  out  32  queue head to decoder (0 when empty)
- dec_is_vconfig  in  1  decoder feedback
- dec_v_alu_op  in  4  decoder feedback
- dec_is_mul  in  1  decoder feedback
- dec_v_red_op  in  3  decoder feedback
- dec_v_sldu_op  in  3  decoder feedback
- dec_v_lsu_op  in  4  decoder feedback
- dec_is_vstype  in  1  decoder feedback
- dec_v_op_sel_A  in  3  decoder feedback
- dec_v_op_sel_B  in  2  decoder feedback
- dec_vd  in  5  decoder feedback
- dec_vs1  in  5  decoder feedback
- dec_vs2  in  5  decoder feedback
- dec_zimm  in  11  decoder feedback
- issue_valid  out  1  issue request
- issue_unit  out  5  one-hot target: [0]ALU [1]MUL [2]RED [3]SLDU [4]LSU
- issue_instr  out  32  issued instruction
- issue_rs1  out  XLEN  issued rs1 value
- issue_rs2  out  XLEN  issued rs2 value
- issue_ready  in  1  target unit accepts
- unit_busy  in  5  per-unit busy, same bit order as issue_unit
- unit_done  in  5  per-unit one-cycle completion pulse (writeback done)
- vl  out  XLEN  current vector length
- vtype  out  11  current vtype
- illegal_instr  out  1  one-cycle pulse when an undecodable head is dropped
- seq_idle  out  1  queue empty, FSM idle, scoreboard clear

Behaviour:
- Reset (synchronous, rst high at a clk edge) clears all state:
  - Queue pointers and count, scoreboard, FSM, per-unit vd records.
  - Outputs: vl=0, vtype=0, issue_valid=0, illegal_instr=0, seq_idle=1, instr_ready=1, issue_unit=0.
  - Any instruction in flight or awaiting ack is discarded. Completion pulses arriving during reset are ignored.
- Queue:
  - Push when instr_valid && instr_ready. Each entry stores {instr, rs1_data, rs2_data}.
  - instr_ready = !full. No push bypass when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop in a non-full, non-empty queue leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - S_IDLE: queue empty. Go to S_CHECK when count becomes nonzero; a pushed entry is visible on dec_instr the cycle after the push.
  - S_CHECK: evaluate the decoded head combinationally.
    - vconfig: update vl/vtype at the clock edge, pop, stay in S_CHECK if more entries remain, else go to S_IDLE. One cycle per vconfig; no hazard check.
    - No unit selected (not vconfig): pulse illegal_instr, pop, same next-state rule.
    - Otherwise, if no hazard and the target unit is not busy: assert issue_valid and go to S_ISSUE.
  - S_ISSUE: issue_valid held high and all issue_* outputs stable until issue_ready. On the handshake: pop, update scoreboard, then go to S_CHECK or S_IDLE.
  - Throughput: 1 issue per 2 cycles maximum.
- Unit select, priority order: lsu_op != 0 selects LSU; else is_mul selects MUL; else red_op != 0 selects RED; else sldu_op != 0 selects SLDU; else alu_op != 0 selects ALU.
- vconfig arithmetic:
  - vtype = zimm.
  - AVL = rs1_data. If instr[19:15]==0 and instr[11:7]!=0, AVL = VLMAX.
  - vl = min(AVL, VLMAX), unsigned compare.
- Scoreboard: 32-bit pending vector.
  - At issue of any non-store: set pending[vd] and record vd for the target unit.
  - On unit_done[u]: clear pending[recorded vd of u]. Multiple done bits in one cycle are all honoured.
  - Set and clear of the same register in one cycle: set wins.
- Hazard: stall in S_CHECK if any of the following holds:
  - sel_A==1 and pending[vs1]
  - is_vstype and pending[vs1] (store data register)
  - sel_B==1 and pending[vs2]
  - non-store and pending[vd] (WAW)
- seq_idle = (state==S_IDLE) && pending==0.

Decomposition:
- v_pkg (shared package) gains:
  - Unit index constants UNIT_ALU..UNIT_LSU and NUM_VUNITS=5.
  - FSM state enum seq_state_t {S_IDLE, S_CHECK, S_ISSUE}.
  - Typedef for the queue entry struct.
- One sub-module: v_instr_fifo, a parameterised synchronous FIFO with count, full and empty. Scoreboard and FSM stay in the top module.

Test Plan:
- vsetvli with rs1_data=100, rs1 field≠0, VLMAX=32 -> vl=32, vtype=zimm two cycles after push. Then rs1_data=7 -> vl=7. No issue_valid during either.
- vadd.vv v3,v1,v2 then vadd.vv v4,v3,v3 -> first issues to ALU (issue_unit=5'b00001). Second stalls until unit_done[0] pulses, issues the cycle after.
- Push 5 instructions back-to-back with issue_ready=0 and FIFO_DEPTH=4 -> instr_ready drops after 4 pushes. First pop re-asserts instr_ready; no push is accepted while full.
- vmul.vv to v5 while unit_busy[1]=1 -> issue_valid stays 0. Drop busy -> issue_unit=5'b00010; issue_rs1/issue_rs2 equal the captured values.
- Head instruction with opcode 0x00 -> illegal_instr pulses for 1 cycle, entry popped, no issue, scoreboard unchanged.
- Assert rst while in S_ISSUE with 3 entries queued and pending[3]=1 -> next cycle issue_valid=0, seq_idle=1, instr_ready=1, vl=0.
